buff_uart_arbiter: RTL
======================

BUFF_UART_ARBITER -- requirements
Module: buff_uart_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one buff_uart bus (2..8).
REQ-002 Parameter WIDTH, default 8, data word width; equals the buff_uart width.
REQ-003 Parameter ADDRESS_WIDTH, default 4, bus address width.
REQ-004 Parameter READ_LATENCY, default 1, cycles from bus_read_enable high to valid bus_data_out (1..4).
REQ-005 clock  input  1  sole clock; all state on posedge clock.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 req  input  NUM_REQ  per-requester transaction request, level, held until ack.
REQ-008 op_write  input  NUM_REQ  per-requester op: 1 = write, 0 = read.
REQ-009 addr  input  NUM_REQ*ADDRESS_WIDTH  per-requester target address, slice i = requester i.
REQ-010 wdata  input  NUM_REQ*WIDTH  per-requester write data, slice i = requester i.
REQ-011 grant  output  NUM_REQ  one-hot, owner of current transaction; all-zero when idle.
REQ-012 ack  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-013 rdata  output  WIDTH  read result, valid in the ack cycle of a read.
REQ-014 busy  output  1  high whenever the FSM is not IDLE.
REQ-015 bus_active_address  output  ADDRESS_WIDTH  to buff_uart active_address.
REQ-016 bus_write_enable / bus_read_enable  output  1 each  to buff_uart write_enable / read_enable.
REQ-017 bus_data_in  output  WIDTH  to buff_uart data_in.
REQ-018 bus_data_out  input  WIDTH  from buff_uart data_out.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT_READ, ACK.
REQ-020 IDLE: if any req bit high at posedge, latch winner, its op, addr, wdata; go ISSUE; else stay.
REQ-021 Winner = first req bit set scanning from rr_ptr upward, wrapping NUM_REQ-1 -> 0.
REQ-022 ISSUE lasts exactly one cycle: bus_active_address = latched addr; exactly one of bus_write_enable / bus_read_enable high per latched op; bus_data_in = latched wdata.
REQ-023 ISSUE -> ACK for write; ISSUE -> WAIT_READ for read.
REQ-024 WAIT_READ lasts READ_LATENCY cycles (down-counter); bus_data_out captured into rdata at the posedge ending the last WAIT_READ cycle; then ACK.
REQ-025 ACK lasts one cycle: ack[owner] = 1, rdata held; rr_ptr <= (owner+1) mod NUM_REQ; next IDLE.
REQ-026 Latency from req sampled in IDLE at cycle T: write ack at T+2; read ack at T+2+READ_LATENCY.
REQ-027 Both bus enables low in every state except ISSUE; bus_active_address and bus_data_in zero outside ISSUE.
REQ-028 grant one-hot for owner in ISSUE, WAIT_READ, ACK; zero in IDLE.
REQ-029 req/op/addr/wdata changes after latch ignored; transaction completes and acks even if owner drops req.
REQ-030 req dropped before being latched: request is lost, no ack.
REQ-031 Requester keeping req high across its ack starts a new transaction only when next selected by round-robin; no back-to-back starvation of others.
REQ-032 rdata retains last read value outside ACK; write ack leaves rdata unchanged.

Reset
REQ-033 resetn low: state IDLE, rr_ptr 0, counter 0, grant/ack/busy/bus enables 0, bus_active_address/bus_data_in/rdata 0, immediately (asynchronous).
REQ-034 Reset mid-transaction aborts it with no ack; first post-reset arbitration starts from requester 0.

Structure
REQ-035 Package buff_uart_arb_pkg holds state enum typedef and op typedef (OP_READ, OP_WRITE).
REQ-036 Sub-module rr_picker: combinational, inputs req and rr_ptr, outputs one-hot winner and index, parameterised on NUM_REQ.

Verification
REQ-037 Single write: req[2]=1, op_write=1, addr=3, wdata=8'hA5 at T -> bus_write_enable, addr 3, data A5 at T+1 only; ack[2] at T+2.
REQ-038 Single read, READ_LATENCY=2: req[0] read addr 5, bus_data_out=8'h3C at T+3 -> bus_read_enable at T+1; ack[0] at T+4 with rdata=3C.
REQ-039 All four req held high continuously, writes -> grants in order 0,1,2,3,0,...; each requester acked once per 4 transactions.
REQ-040 rr_ptr=3, req=4'b0101 -> winner 0, then 2.
REQ-041 resetn pulsed low during WAIT_READ -> no ack, all outputs 0 same cycle; next req[1] serviced normally from requester-0 pointer.
REQ-042 Owner drops req during ISSUE -> ack still pulses at expected cycle; non-latched requester dropping req in IDLE -> no bus activity, no ack.

Source files
------------

// File: rtl/buff_uart_arb_pkg.sv
// Shared types for the buff_uart arbiter: FSM state encoding and the
// per-requester operation type.
package buff_uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_READ = 2'd2,
      ST_ACK       = 2'd3
   } state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_t;

   // Read latency is bounded to 1..4, so the wait counter only needs 0..3.
   localparam int CNT_W = 2;

endpackage

// File: rtl/buff_uart_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit at or above rr_ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic [IDX_W-1:0]   winner_idx,
   output logic               found
);

   always_comb begin
      int pos;
      pos        = 0;
      winner     = '0;
      winner_idx = '0;
      found      = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = int'(rr_ptr) + k;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         if (!found && req[pos]) begin
            found       = 1'b1;
            winner[pos] = 1'b1;
            winner_idx  = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/buff_uart_arbiter.sv
// Round-robin arbiter letting NUM_REQ requesters share one buff_uart bus.
// Handshake: req is a level held by the requester; the arbiter latches the
// winner's op/addr/wdata in IDLE and answers with a one-cycle ack[owner].
module buff_uart_arbiter
   import buff_uart_arb_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int WIDTH         = 8,
   parameter int ADDRESS_WIDTH = 4,
   parameter int READ_LATENCY  = 1
) (
   input  logic                             clock,
   input  logic                             resetn,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ-1:0]               op_write,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] addr,
   input  logic [NUM_REQ*WIDTH-1:0]         wdata,
   output logic [NUM_REQ-1:0]               grant,
   output logic [NUM_REQ-1:0]               ack,
   output logic [WIDTH-1:0]                 rdata,
   output logic                             busy,
   output logic [ADDRESS_WIDTH-1:0]         bus_active_address,
   output logic                             bus_write_enable,
   output logic                             bus_read_enable,
   output logic [WIDTH-1:0]                 bus_data_in,
   input  logic [WIDTH-1:0]                 bus_data_out,
   output state_t                           dbg_state
);

   localparam int IDX_W = $clog2(NUM_REQ);

   state_t           state;
   op_t              op_q;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] owner;
   logic [CNT_W-1:0] cnt;

   logic [NUM_REQ-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_found;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req        (req),
      .rr_ptr     (rr_ptr),
      .winner     (pick_oh),
      .winner_idx (pick_idx),
      .found      (pick_found)
   );

   assign dbg_state = state;

   // All outputs are registered; bus address/data registers double as the
   // latched copy of the winner's request, so they are cleared after ISSUE.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state              <= ST_IDLE;
         op_q               <= OP_READ;
         rr_ptr             <= '0;
         owner              <= '0;
         cnt                <= '0;
         grant              <= '0;
         ack                <= '0;
         rdata              <= '0;
         busy               <= 1'b0;
         bus_active_address <= '0;
         bus_write_enable   <= 1'b0;
         bus_read_enable    <= 1'b0;
         bus_data_in        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  state              <= ST_ISSUE;
                  owner              <= pick_idx;
                  op_q               <= op_t'(op_write[pick_idx]);
                  grant              <= pick_oh;
                  busy               <= 1'b1;
                  bus_active_address <= addr[int'(pick_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                  bus_data_in        <= wdata[int'(pick_idx)*WIDTH +: WIDTH];
                  bus_write_enable   <= op_write[pick_idx];
                  bus_read_enable    <= !op_write[pick_idx];
               end
            end
            ST_ISSUE: begin
               bus_active_address <= '0;
               bus_data_in        <= '0;
               bus_write_enable   <= 1'b0;
               bus_read_enable    <= 1'b0;
               if (op_q == OP_WRITE) begin
                  state <= ST_ACK;
                  ack   <= grant;
               end else begin
                  state <= ST_WAIT_READ;
                  cnt   <= CNT_W'(READ_LATENCY - 1);
               end
            end
            ST_WAIT_READ: begin
               if (cnt == '0) begin
                  rdata <= bus_data_out;
                  ack   <= grant;
                  state <= ST_ACK;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_ACK: begin
               ack    <= '0;
               grant  <= '0;
               busy   <= 1'b0;
               rr_ptr <= (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
